sound_player: RTL

Square-wave tone generator driving the board's speaker/buzzer pin. Consumes the one-cycle event pulses the ball logic emits on brick hits (`play_sound1`) and paddle hits / ball lost (`play_sound2`), and turns each into a fixed-length audible tone. It sits between the game-logic domain and the audio output pin, in the same clock domain as the ball logic.

---
 rtl/sound_player_if.sv | 24 ++
 rtl/sound_player.sv | 119 +++++++++++
 2 files changed

// File: rtl/sound_player_if.sv
// Event/audio bundle between the game logic (master) and the tone generator (slave).
interface sound_player_if;
    logic       play_sound1;
    logic       play_sound2;
    logic       speaker;
    logic       busy;
    logic [1:0] tone_id;

    modport master (
        output play_sound1,
        output play_sound2,
        input  speaker,
        input  busy,
        input  tone_id
    );

    modport slave (
        input  play_sound1,
        input  play_sound2,
        output speaker,
        output busy,
        output tone_id
    );
endinterface

// File: rtl/sound_player.sv
// Square-wave tone generator turning brick/paddle event pulses into fixed-length tones.
// Optional falling-pitch sweep on tone 2 is enabled by defining SOUND_SWEEP_EN.
module sound_player #(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned HALF1      = 25000,
    parameter int unsigned HALF2      = 12500,
    parameter int unsigned TONE_LEN   = 2500000,
    parameter int unsigned SWEEP_STEP = 500
) (
    input  logic           clk,
    input  logic           reset,
    sound_player_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TONE1 = 2'd1,
        TONE2 = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HALF1_C   = CNT_W'(HALF1);
    localparam logic [CNT_W-1:0] HALF2_C   = CNT_W'(HALF2);
    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_LEN - 1);
    localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(SWEEP_STEP);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

`ifdef SOUND_SWEEP_EN
    localparam bit SWEEP_ON = 1'b1;
`else
    localparam bit SWEEP_ON = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] halfCnt_q, halfCnt_d;
    logic [CNT_W-1:0] durCnt_q, durCnt_d;
    logic [CNT_W-1:0] halfPeriod_q, halfPeriod_d;
    logic             speaker_q, speaker_d;
    logic             busy_q, busy_d;
    logic [1:0]       toneId_q, toneId_d;
    logic             p1_q, p2_q;

    logic             rise1, rise2;
    logic [CNT_W:0]   sweepSum;
    logic [CNT_W-1:0] sweepHalf;

    assign rise1 = bus.play_sound1 & ~p1_q;
    assign rise2 = bus.play_sound2 & ~p2_q;

    // The extra carry bit lets the sweep clamp at the counter maximum instead of wrapping.
    assign sweepSum  = {1'b0, halfPeriod_q} + {1'b0, STEP_C};
    assign sweepHalf = sweepSum[CNT_W] ? '1 : sweepSum[CNT_W-1:0];

    always_comb begin
        state_d      = state_q;
        halfCnt_d    = halfCnt_q;
        durCnt_d     = durCnt_q;
        halfPeriod_d = halfPeriod_q;
        speaker_d    = speaker_q;

        if (rise1 || rise2) begin
            state_d      = rise2 ? TONE2 : TONE1;
            halfCnt_d    = '0;
            durCnt_d     = '0;
            speaker_d    = 1'b1;
            halfPeriod_d = rise2 ? HALF2_C : HALF1_C;
        end else if (state_q != IDLE) begin
            if (durCnt_q == TONE_LAST) begin
                state_d   = IDLE;
                halfCnt_d = '0;
                durCnt_d  = '0;
                speaker_d = 1'b0;
            end else begin
                durCnt_d = durCnt_q + ONE;
                if (halfCnt_q == halfPeriod_q - ONE) begin
                    halfCnt_d = '0;
                    speaker_d = ~speaker_q;
                    // A low-to-high toggle closes a full period; that is where the sweep lengthens it.
                    if (SWEEP_ON && (state_q == TONE2) && !speaker_q) begin
                        halfPeriod_d = sweepHalf;
                    end
                end else begin
                    halfCnt_d = halfCnt_q + ONE;
                end
            end
        end

        busy_d   = (state_d != IDLE);
        toneId_d = state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            halfCnt_q    <= '0;
            durCnt_q     <= '0;
            halfPeriod_q <= HALF1_C;
            speaker_q    <= 1'b0;
            busy_q       <= 1'b0;
            toneId_q     <= 2'd0;
            p1_q         <= 1'b0;
            p2_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            halfCnt_q    <= halfCnt_d;
            durCnt_q     <= durCnt_d;
            halfPeriod_q <= halfPeriod_d;
            speaker_q    <= speaker_d;
            busy_q       <= busy_d;
            toneId_q     <= toneId_d;
            p1_q         <= bus.play_sound1;
            p2_q         <= bus.play_sound2;
        end
    end

    assign bus.speaker = speaker_q;
    assign bus.busy    = busy_q;
    assign bus.tone_id = toneId_q;

endmodule
